// File: rtl/bt_uart_pkg.sv
// Shared definitions for the Bluetooth UART receiver and transmitter:
// FSM state encoding, frame geometry and the default bit period.
package bt_uart_pkg;

    localparam int FRAME_BITS       = 11;
    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 5208;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Returns 1 when data plus the received parity bit do not give the
    // expected overall parity (0 = even, 1 = odd).
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                             input logic                 par_bit,
                                             input logic                 odd);
        return (((^data) ^ par_bit) != odd);
    endfunction

endpackage

// File: rtl/bt_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module bt_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bt_uart_rx.sv
// UART receiver for the Bluetooth module link: 11-bit frame
// (start, 8 data LSB first, parity, stop), mid-bit sampling,
// valid/ready output with overrun indication.
module bt_uart_rx
    import bt_uart_pkg::*;
#(
    parameter int   CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter logic PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 stop_bit_q, stop_bit_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] dout_q;
    logic                 valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;

    bt_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // FSM and datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            idx_q      <= 3'd0;
            shift_q    <= {DATA_BITS{1'b0}};
            par_err_q  <= 1'b0;
            stop_bit_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            stop_bit_q <= stop_bit_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: start qualification at half a bit, then sample
    // every full bit period so each sample lands mid-bit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        stop_bit_d = stop_bit_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = {CNT_W{1'b0}};
                    idx_d = 3'd0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;  // glitch, not a real start bit
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = {CNT_W{1'b0}};
                    par_err_d = parity_mismatch(shift_q, rx_s, PARITY_ODD);
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = {CNT_W{1'b0}};
                    stop_bit_d = rx_s;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output holding register: a completed frame always loads, even over
    // an unconsumed byte; overrun flags that loss only when not being read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= {DATA_BITS{1'b0}};
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (done_q) begin
            dout_q       <= shift_q;
            valid_q      <= 1'b1;
            parity_err_q <= par_err_q;
            frame_err_q  <= ~stop_bit_q;
            overrun_q    <= valid_q & ~ready;
        end else begin
            overrun_q <= 1'b0;
            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_q;
            end
        end
    end

    // Registered busy flag, tracking the FSM leaving IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
        end
    end

    assign dout       = dout_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bt_uart_rx.sv
// Directed bench for bt_uart_rx with CLKS_PER_BIT = 16.
module tb_bt_uart_rx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;
    int ovr_cnt  = 0;
    int rise_cnt = 0;
    logic valid_prev = 1'b0;
    int ovr_base;
    int rise_base;

    bt_uart_rx #(.CLKS_PER_BIT(16), .PARITY_ODD(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .ready      (ready),
        .dout       (dout),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Count overrun pulse cycles and valid rising edges shortly after each edge.
    always @(posedge clk) begin
        #2;
        if (overrun) ovr_cnt++;
        if (valid && !valid_prev) rise_cnt++;
        valid_prev = valid;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // Drives bit c/16 of the frame before the c-th rising edge. Stop sample
    // is at edge 170, so valid must be 0 after it and 1 after edge 171.
    task automatic send_frame(input logic [10:0] bits, input int ncyc,
                              input bit chk_lat, input int rdy_c);
        logic [3:0] bi;
        for (int c = 0; c < ncyc; c++) begin
            bi = 4'(c / 16);
            rx = bits[bi];
            if (c == rdy_c) ready = 1'b1;
            @(negedge clk);
            if (c == rdy_c) ready = 1'b0;
            if (chk_lat && c == 170) check_val("lat_before", 32'(valid), 32'd0);
            if (chk_lat && c == 171) check_val("lat_after",  32'(valid), 32'd1);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic consume();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_dout",    32'(dout),       32'h00);
        check_val("rst_valid",   32'(valid),      32'd0);
        check_val("rst_perr",    32'(parity_err), 32'd0);
        check_val("rst_ferr",    32'(frame_err),  32'd0);
        check_val("rst_ovr",     32'(overrun),    32'd0);
        check_val("rst_busy",    32'(busy),       32'd0);
        rst_n = 1'b1;
        idle(5);

        // Scenario 1: clean 0x55, even parity 0
        send_frame(mk_frame(8'h55, 1'b0, 1'b1), 176, 1'b1, -1);
        check_val("s1_dout",  32'(dout),       32'h55);
        check_val("s1_valid", 32'(valid),      32'd1);
        check_val("s1_perr",  32'(parity_err), 32'd0);
        check_val("s1_ferr",  32'(frame_err),  32'd0);
        check_val("s1_busy",  32'(busy),       32'd0);
        consume();
        check_val("s1_cons",  32'(valid),      32'd0);

        // Scenario 2: parity error on 0xA3, framing error on 0x00
        idle(4);
        send_frame(mk_frame(8'hA3, 1'b1, 1'b1), 176, 1'b0, -1);
        check_val("s2_dout",  32'(dout),       32'hA3);
        check_val("s2_perr",  32'(parity_err), 32'd1);
        check_val("s2_ferr",  32'(frame_err),  32'd0);
        consume();
        send_frame(mk_frame(8'h00, 1'b0, 1'b0), 176, 1'b0, -1);
        idle(40);
        check_val("s2b_dout",  32'(dout),       32'h00);
        check_val("s2b_valid", 32'(valid),      32'd1);
        check_val("s2b_ferr",  32'(frame_err),  32'd1);
        check_val("s2b_perr",  32'(parity_err), 32'd0);
        consume();

        // Scenario 3: 5-cycle low glitch
        rise_base = rise_cnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check_val("s3_busy_on",  32'(busy),  32'd1);
        idle(30);
        check_val("s3_busy_off", 32'(busy),  32'd0);
        check_val("s3_valid",    32'(valid), 32'd0);
        check_val("s3_rises",    32'(rise_cnt - rise_base), 32'd0);

        // Scenario 4: back-to-back 0x11, 0x22 with ready low
        ovr_base = ovr_cnt;
        send_frame(mk_frame(8'h11, 1'b0, 1'b1), 176, 1'b0, -1);
        send_frame(mk_frame(8'h22, 1'b0, 1'b1), 176, 1'b0, -1);
        check_val("s4_dout",  32'(dout),  32'h22);
        check_val("s4_valid", 32'(valid), 32'd1);
        check_val("s4_ovr",   32'(ovr_cnt - ovr_base), 32'd1);
        consume();
        check_val("s4_cons",  32'(valid), 32'd0);
        idle(4);
        check_val("s4_ovr2",  32'(ovr_cnt - ovr_base), 32'd1);

        // Scenario 5: reset during data bit 4 of 0xFF, then clean 0x3C
        send_frame(mk_frame(8'hFF, 1'b0, 1'b1), 90, 1'b0, -1);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check_val("s5_rst_busy",  32'(busy),  32'd0);
        check_val("s5_rst_valid", 32'(valid), 32'd0);
        rst_n = 1'b1;
        rise_base = rise_cnt;
        idle(40);
        check_val("s5_idle_valid", 32'(valid), 32'd0);
        send_frame(mk_frame(8'h3C, 1'b0, 1'b1), 176, 1'b0, -1);
        check_val("s5_dout",  32'(dout),       32'h3C);
        check_val("s5_valid", 32'(valid),      32'd1);
        check_val("s5_perr",  32'(parity_err), 32'd0);
        check_val("s5_ferr",  32'(frame_err),  32'd0);
        check_val("s5_rises", 32'(rise_cnt - rise_base), 32'd1);

        // Scenario 6: transmitter frame 11'b10010101010 (0x55); ready is
        // pulsed in the load cycle while 0x3C is still pending
        ovr_base = ovr_cnt;
        send_frame(11'b10010101010, 176, 1'b0, 171);
        check_val("s6_dout",  32'(dout),       32'h55);
        check_val("s6_valid", 32'(valid),      32'd1);
        check_val("s6_perr",  32'(parity_err), 32'd0);
        check_val("s6_ferr",  32'(frame_err),  32'd0);
        check_val("s6_ovr",   32'(ovr_cnt - ovr_base), 32'd0);
        consume();
        check_val("s6_cons",  32'(valid),      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
